// File: rtl/aurora_link_supervisor.sv
// Aurora lane bring-up supervisor: sequences GT/core/user resets, retries on timeout,
// debounces channel_up and declares failure once the retry budget is spent.
module aurora_link_supervisor #(
  parameter int GT_RESET_CYCLES   = 128,
  parameter int PMA_SETTLE_CYCLES = 64,
  parameter int LINK_TIMEOUT      = 65536,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int MAX_RETRIES       = 4,
  parameter int CNT_W             = 20,
  parameter int RTY_W             = 3
) (
  input  logic             init_clk,
  input  logic             RST_n,
  input  logic             enable,
  input  logic             force_retrain,
  input  logic             channel_up,
  output logic             gt_reset,
  output logic             reset_Aurora,
  output logic             reset_TX_RX_Block,
  output logic             link_ok,
  output logic             link_failed,
  output logic [RTY_W-1:0] retry_count,
  output logic [2:0]       state
);

  // state    | meaning
  // IDLE     | disabled, every reset held
  // GT_RST   | gt_reset pulse, GT_RESET_CYCLES long
  // AUR_RST  | PMA settle with core reset held
  // WAIT_UP  | resets released, waiting for channel_up, timeout running
  // DEBOUNCE | channel_up seen, must stay high DEBOUNCE_CYCLES
  // UP       | link usable, user datapath out of reset
  // FAIL     | retries exhausted, every reset held
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GT_RST   = 3'd1,
    S_AUR_RST  = 3'd2,
    S_WAIT_UP  = 3'd3,
    S_DEBOUNCE = 3'd4,
    S_UP       = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GT_LAST  = CNT_W'(GT_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] PMA_LAST = CNT_W'(PMA_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  state_t           cur, nxt;
  logic             cu_s1, cu_s2;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
  logic [RTY_W-1:0] retry_nxt;
  logic             restart, timed_out, in_wait, nxt_wait, timed_state;

  assign restart     = enable && force_retrain && (cur != S_IDLE);
  assign timed_out   = (to_cnt == TO_LAST);
  assign in_wait     = (cur == S_WAIT_UP) || (cur == S_DEBOUNCE);
  assign nxt_wait    = (nxt == S_WAIT_UP) || (nxt == S_DEBOUNCE);
  assign timed_state = (cur == S_GT_RST) || (cur == S_AUR_RST) || (cur == S_DEBOUNCE);
  assign state       = cur;

  always_comb begin
    nxt       = cur;
    retry_nxt = retry_count;
    if (!enable) begin
      nxt       = S_IDLE;
      retry_nxt = '0;
    end else if (restart) begin
      nxt       = S_GT_RST;
      retry_nxt = '0;
    end else begin
      case (cur)
        S_IDLE: begin
          nxt       = S_GT_RST;
          retry_nxt = '0;
        end
        S_GT_RST:  if (timer == GT_LAST) nxt = S_AUR_RST;
        S_AUR_RST: if (timer == PMA_LAST) nxt = S_WAIT_UP;
        S_WAIT_UP, S_DEBOUNCE: begin
          // The timeout spans both waiting states, so it wins over channel_up events.
          if (timed_out) begin
            if (retry_count < RTY_MAX) begin
              nxt       = S_GT_RST;
              retry_nxt = retry_count + RTY_W'(1);
            end else begin
              nxt = S_FAIL;
            end
          end else if (cur == S_WAIT_UP) begin
            if (cu_s2) nxt = S_DEBOUNCE;
          end else if (!cu_s2) begin
            nxt = S_WAIT_UP;
          end else if (timer == DB_LAST) begin
            nxt       = S_UP;
            retry_nxt = '0;
          end
        end
        S_UP:    if (!cu_s2) nxt = S_WAIT_UP;
        S_FAIL:  nxt = S_FAIL;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    timer_nxt  = '0;
    to_cnt_nxt = '0;
    if (!restart && timed_state && (nxt == cur)) timer_nxt = timer + CNT_W'(1);
    // Bouncing between WAIT_UP and DEBOUNCE keeps the timeout running.
    if (in_wait && nxt_wait) to_cnt_nxt = to_cnt + CNT_W'(1);
  end

  always_ff @(posedge init_clk or negedge RST_n) begin
    if (!RST_n) begin
      cu_s1             <= 1'b0;
      cu_s2             <= 1'b0;
      cur               <= S_IDLE;
      timer             <= '0;
      to_cnt            <= '0;
      retry_count       <= '0;
      gt_reset          <= 1'b1;
      reset_Aurora      <= 1'b1;
      reset_TX_RX_Block <= 1'b1;
      link_ok           <= 1'b0;
      link_failed       <= 1'b0;
    end else begin
      cu_s1             <= channel_up;
      cu_s2             <= cu_s1;
      cur               <= nxt;
      timer             <= timer_nxt;
      to_cnt            <= to_cnt_nxt;
      retry_count       <= retry_nxt;
      gt_reset          <= (nxt == S_IDLE) || (nxt == S_GT_RST) || (nxt == S_FAIL);
      reset_Aurora      <= (nxt == S_IDLE) || (nxt == S_GT_RST) || (nxt == S_AUR_RST) ||
                           (nxt == S_FAIL);
      reset_TX_RX_Block <= (nxt != S_UP);
      link_ok           <= (nxt == S_UP);
      link_failed       <= (nxt == S_FAIL);
    end
  end

endmodule
